// File: rtl/lcd_spi_rx_if.sv
// Link and decoded-output bundle for the serial LCD receiver.
interface lcd_spi_rx_if;
  logic        sda;
  logic        scl;
  logic        cs;
  logic        rs;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_rs;
  logic        pixel_valid;
  logic [15:0] pixel;
  logic [7:0]  px;
  logic [7:0]  py;
  logic        frame_start;
  logic        frame_error;

  // Link driver side (transmitter / bench).
  modport master (
    output sda, scl, cs, rs,
    input  byte_valid, byte_data, byte_rs, pixel_valid, pixel, px, py,
           frame_start, frame_error
  );

  // Receiver side.
  modport slave (
    input  sda, scl, cs, rs,
    output byte_valid, byte_data, byte_rs, pixel_valid, pixel, px, py,
           frame_start, frame_error
  );
endinterface

// File: rtl/lcd_spi_rx.sv
// Oversampling receiver for the 3-wire LCD link: deserialises bytes and
// decodes CASET/RASET/RAMWR into addressed RGB565 pixels.
module lcd_spi_rx #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  CMD_CASET   = 8'h2A,
  parameter logic [7:0]  CMD_RASET   = 8'h2B,
  parameter logic [7:0]  CMD_RAMWR   = 8'h2C
) (
  input  logic           clk,
  input  logic           reset,
  lcd_spi_rx_if.slave    bus
);

  localparam int unsigned SYNC_W = 4;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned PIX_W  = 16;
  // Idle link as seen after reset: cs high, everything else low ({rs,cs,scl,sda}).
  localparam logic [SYNC_W-1:0] SYNC_IDLE = 4'b0100;

  typedef enum logic [1:0] {ST_IDLE, ST_COL, ST_ROW, ST_PIX} state_e;

  logic [SYNC_STAGES-1:0][SYNC_W-1:0] sync_q, sync_d;
  logic              scl_prev_q, scl_prev_d;
  logic              sda_s, scl_s, cs_s, rs_s, rise_c, abort_c;
  logic [2:0]        cnt_q, cnt_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic              byte_valid_q, byte_valid_d;
  logic [BYTE_W-1:0] byte_data_q, byte_data_d;
  logic              byte_rs_q, byte_rs_d;

  state_e            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [BYTE_W-1:0] xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
  logic [BYTE_W-1:0] col_q, col_d, row_q, row_d;
  logic              half_q, half_d;
  logic [BYTE_W-1:0] hi_q, hi_d;
  logic              pixel_valid_q, pixel_valid_d;
  logic [PIX_W-1:0]  pixel_q, pixel_d;
  logic [BYTE_W-1:0] px_q, px_d, py_q, py_d;
  logic              frame_start_q, frame_start_d;
  logic              frame_error_q, frame_error_d;

  assign sda_s  = sync_q[SYNC_STAGES-1][0];
  assign scl_s  = sync_q[SYNC_STAGES-1][1];
  assign cs_s   = sync_q[SYNC_STAGES-1][2];
  assign rs_s   = sync_q[SYNC_STAGES-1][3];
  assign rise_c = scl_s & ~scl_prev_q;

  // Synchroniser chain, scl edge detect and bit/byte assembly.
  always_comb begin
    sync_d[0] = {bus.rs, bus.cs, bus.scl, bus.sda};
    for (int i = 1; i < int'(SYNC_STAGES); i++) sync_d[i] = sync_q[i-1];
    scl_prev_d   = scl_s;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    byte_data_d  = byte_data_q;
    byte_rs_d    = byte_rs_q;
    abort_c      = 1'b0;
    if (cs_s) begin
      cnt_d   = 3'd0;
      abort_c = (cnt_q != 3'd0);
    end else if (rise_c) begin
      shift_d = {shift_q[BYTE_W-2:0], sda_s};
      cnt_d   = cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        byte_valid_d = 1'b1;
        byte_data_d  = {shift_q[BYTE_W-2:0], sda_s};
        byte_rs_d    = rs_s;
      end
    end
  end

  // Deserialiser registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q       <= {SYNC_STAGES{SYNC_IDLE}};
      scl_prev_q   <= 1'b0;
      cnt_q        <= 3'd0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= '0;
      byte_rs_q    <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      scl_prev_q   <= scl_prev_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      byte_data_q  <= byte_data_d;
      byte_rs_q    <= byte_rs_d;
    end
  end

  // Command decoder: window capture, pixel pairing and cursor advance.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    xs_d          = xs_q;
    xe_d          = xe_q;
    ys_d          = ys_q;
    ye_d          = ye_q;
    col_d         = col_q;
    row_d         = row_q;
    half_d        = half_q;
    hi_d          = hi_q;
    pixel_valid_d = 1'b0;
    pixel_d       = pixel_q;
    px_d          = px_q;
    py_d          = py_q;
    frame_start_d = 1'b0;
    frame_error_d = frame_error_q;
    if (byte_valid_q) begin
      if (!byte_rs_q) begin
        idx_d  = 2'd0;
        half_d = 1'b0;
        if (byte_data_q == CMD_CASET) begin
          state_d = ST_COL;
        end else if (byte_data_q == CMD_RASET) begin
          state_d = ST_ROW;
        end else if (byte_data_q == CMD_RAMWR) begin
          state_d       = ST_PIX;
          col_d         = xs_q;
          row_d         = ys_q;
          frame_start_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end else begin
        case (state_q)
          ST_COL, ST_ROW: begin
            if (idx_q == 2'd1) begin
              if (state_q == ST_COL) xs_d = byte_data_q;
              else                   ys_d = byte_data_q;
            end
            if (idx_q == 2'd3) begin
              if (state_q == ST_COL) xe_d = byte_data_q;
              else                   ye_d = byte_data_q;
              state_d = ST_IDLE;
            end
            idx_d = idx_q + 2'd1;
          end
          ST_PIX: begin
            if (!half_q) begin
              hi_d   = byte_data_q;
              half_d = 1'b1;
            end else begin
              half_d        = 1'b0;
              pixel_valid_d = 1'b1;
              pixel_d       = {hi_q, byte_data_q};
              px_d          = col_q;
              py_d          = row_q;
              if (col_q == xe_q) begin
                col_d = xs_q;
                row_d = (row_q == ye_q) ? ys_q : row_q + 8'd1;
              end else begin
                col_d = col_q + 8'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
    if (frame_start_d) frame_error_d = 1'b0;
    if (abort_c)       frame_error_d = 1'b1;
  end

  // Decoder registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      idx_q         <= 2'd0;
      xs_q          <= 8'h00;
      xe_q          <= 8'hFF;
      ys_q          <= 8'h00;
      ye_q          <= 8'hFF;
      col_q         <= 8'h00;
      row_q         <= 8'h00;
      half_q        <= 1'b0;
      hi_q          <= 8'h00;
      pixel_valid_q <= 1'b0;
      pixel_q       <= '0;
      px_q          <= 8'h00;
      py_q          <= 8'h00;
      frame_start_q <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      xs_q          <= xs_d;
      xe_q          <= xe_d;
      ys_q          <= ys_d;
      ye_q          <= ye_d;
      col_q         <= col_d;
      row_q         <= row_d;
      half_q        <= half_d;
      hi_q          <= hi_d;
      pixel_valid_q <= pixel_valid_d;
      pixel_q       <= pixel_d;
      px_q          <= px_d;
      py_q          <= py_d;
      frame_start_q <= frame_start_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign bus.byte_valid  = byte_valid_q;
  assign bus.byte_data   = byte_data_q;
  assign bus.byte_rs     = byte_rs_q;
  assign bus.pixel_valid = pixel_valid_q;
  assign bus.pixel       = pixel_q;
  assign bus.px          = px_q;
  assign bus.py          = py_q;
  assign bus.frame_start = frame_start_q;
  assign bus.frame_error = frame_error_q;

endmodule

// File: tb/tb_lcd_spi_rx.sv
// Directed + randomized bench for lcd_spi_rx against a window/pixel-index model.
module tb_lcd_spi_rx;
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  lcd_spi_rx_if bus ();

  lcd_spi_rx #(
    .SYNC_STAGES(2), .CMD_CASET(8'h2A), .CMD_RASET(8'h2B), .CMD_RAMWR(8'h2C)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_assert   = 0;
  int n_fail     = 0;
  int got_frames = 0;
  int exp_frames = 0;
  logic [8:0]  got_b[$], exp_b[$];
  logic [31:0] got_p[$], exp_p[$];

  // Reference model state: window, command mode, pixel index since RAMWR.
  logic [7:0] m_xs, m_xe, m_ys, m_ye, m_hi;
  int         m_mode, m_param, m_k;
  bit         m_half, m_ferr;

  logic [7:0] r_s, r_e, r_a, r_b;
  int         r_n;

  // Record every output pulse, sampled away from the active edge.
  always @(negedge clk) begin
    if (bus.byte_valid === 1'b1)  got_b.push_back({bus.byte_rs, bus.byte_data});
    if (bus.pixel_valid === 1'b1) got_p.push_back({bus.pixel, bus.px, bus.py});
    if (bus.frame_start === 1'b1) got_frames++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_xs = 8'h00; m_xe = 8'hFF; m_ys = 8'h00; m_ye = 8'hFF; m_hi = 8'h00;
    m_mode = 0; m_param = 0; m_k = 0; m_half = 0; m_ferr = 0;
    exp_b.delete(); exp_p.delete(); got_b.delete(); got_p.delete();
  endtask

  task automatic model_feed(input bit rs, input logic [7:0] d);
    logic [7:0] span_x, span_y, col, row;
    int w, h;
    if (!rs) begin
      m_param = 0; m_half = 0;
      if (d == 8'h2A)      m_mode = 1;
      else if (d == 8'h2B) m_mode = 2;
      else if (d == 8'h2C) begin m_mode = 3; m_k = 0; exp_frames++; m_ferr = 0; end
      else                 m_mode = 0;
    end else if (m_mode == 1 || m_mode == 2) begin
      if (m_param == 1) begin if (m_mode == 1) m_xs = d; else m_ys = d; end
      if (m_param == 3) begin
        if (m_mode == 1) m_xe = d; else m_ye = d;
        m_mode = 0;
      end
      m_param++;
    end else if (m_mode == 3) begin
      if (!m_half) begin
        m_hi = d; m_half = 1;
      end else begin
        m_half = 0;
        span_x = m_xe - m_xs;
        span_y = m_ye - m_ys;
        w = int'(span_x) + 1;
        h = int'(span_y) + 1;
        col = m_xs + 8'(m_k % w);
        row = m_ys + 8'((m_k / w) % h);
        exp_p.push_back({m_hi, d, col, row});
        m_k++;
      end
    end
  endtask

  task automatic send_bits(input bit rs, input logic [7:0] data, input int nbits);
    @(negedge clk);
    bus.cs = 1'b0;
    bus.rs = rs;
    for (int i = 7; i >= 8 - nbits; i--) begin
      bus.sda = data[i];
      repeat (4) @(negedge clk);
      bus.scl = 1'b1;
      repeat (4) @(negedge clk);
      bus.scl = 1'b0;
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic send_byte(input bit rs, input logic [7:0] data);
    send_bits(rs, data, 8);
    exp_b.push_back({rs, data});
    model_feed(rs, data);
  endtask

  task automatic cs_release(input bit partial);
    @(negedge clk);
    bus.cs = 1'b1;
    if (partial) m_ferr = 1;
    repeat (6) @(negedge clk);
  endtask

  task automatic send_window(input logic [7:0] cmd, input logic [7:0] s, input logic [7:0] e);
    send_byte(1'b0, cmd);
    send_byte(1'b1, 8'($urandom));
    send_byte(1'b1, s);
    send_byte(1'b1, 8'($urandom));
    send_byte(1'b1, e);
  endtask

  task automatic check_traffic(input string tag);
    check({tag, ".nbytes"}, 32'(got_b.size()), 32'(exp_b.size()));
    for (int i = 0; i < exp_b.size() && i < got_b.size(); i++)
      check({tag, ".byte"}, 32'(got_b[i]), 32'(exp_b[i]));
    check({tag, ".npix"}, 32'(got_p.size()), 32'(exp_p.size()));
    for (int i = 0; i < exp_p.size() && i < got_p.size(); i++)
      check({tag, ".pix"}, got_p[i], exp_p[i]);
    check({tag, ".frames"}, 32'(got_frames), 32'(exp_frames));
    check({tag, ".ferr"}, 32'(bus.frame_error), 32'(m_ferr));
    got_b.delete(); exp_b.delete(); got_p.delete(); exp_p.delete();
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".byte_valid"},  32'(bus.byte_valid),  32'd0);
    check({tag, ".byte_data"},   32'(bus.byte_data),   32'd0);
    check({tag, ".byte_rs"},     32'(bus.byte_rs),     32'd0);
    check({tag, ".pixel_valid"}, 32'(bus.pixel_valid), 32'd0);
    check({tag, ".pixel"},       32'(bus.pixel),       32'd0);
    check({tag, ".px"},          32'(bus.px),          32'd0);
    check({tag, ".py"},          32'(bus.py),          32'd0);
    check({tag, ".frame_start"}, 32'(bus.frame_start), 32'd0);
    check({tag, ".frame_error"}, 32'(bus.frame_error), 32'd0);
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_zero(tag);
    bus.cs = 1'b1; bus.scl = 1'b0; bus.sda = 1'b0; bus.rs = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    bus.cs = 1'b1; bus.scl = 1'b0; bus.sda = 1'b0; bus.rs = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // Single command byte.
    send_byte(1'b0, 8'h2A);
    check_traffic("caset_cmd");

    // Window 0x10..0x12 x 5..6, then six red pixels.
    send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h10);
    send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h12);
    send_window(8'h2B, 8'h05, 8'h06);
    send_byte(1'b0, 8'h2C);
    for (int i = 0; i < 6; i++) begin
      send_byte(1'b1, 8'hF8);
      send_byte(1'b1, 8'h00);
    end
    if (got_p.size() == 6) begin
      check("win.first", got_p[0], 32'hF800_1005);
      check("win.last",  got_p[5], 32'hF800_1206);
    end
    check_traffic("window");

    // Cursor wraps back to the window origin.
    for (int i = 0; i < 2; i++) begin
      send_byte(1'b1, 8'hF8);
      send_byte(1'b1, 8'h00);
    end
    if (got_p.size() == 2) check("wrap.first", got_p[0], 32'hF800_1005);
    check_traffic("wrap");

    // Partial byte aborted by cs, then a clean data byte.
    send_bits(1'b1, 8'hA5, 5);
    cs_release(1'b1);
    send_byte(1'b1, 8'h55);
    check("abort.ferr", 32'(bus.frame_error), 32'd1);
    check("abort.data", 32'(bus.byte_data), 32'h55);
    check_traffic("abort");

    // Half pixel discarded by an unrelated command.
    send_byte(1'b0, 8'h2C);
    send_byte(1'b1, 8'h12);
    send_byte(1'b0, 8'h00);
    send_byte(1'b0, 8'h2C);
    send_byte(1'b1, 8'h34);
    send_byte(1'b1, 8'h56);
    if (got_p.size() == 1) check("discard.pix", got_p[0], 32'h3456_1005);
    check_traffic("discard");

    // Reset mid-byte.
    send_bits(1'b1, 8'hFF, 4);
    pulse_reset("rst_byte");
    send_byte(1'b1, 8'h3C);
    check_traffic("after_rst_byte");

    // Reset mid-pixel, then a full pixel in the default window.
    send_byte(1'b0, 8'h2C);
    send_byte(1'b1, 8'hAB);
    pulse_reset("rst_pix");
    send_byte(1'b1, 8'h3C);
    send_byte(1'b0, 8'h2C);
    send_byte(1'b1, 8'hC3);
    send_byte(1'b1, 8'h5A);
    check_traffic("after_rst_pix");

    // Random windows (including wrapping ones) and random pixel streams.
    for (int it = 0; it < 4; it++) begin
      r_s = 8'($urandom);
      r_e = r_s + 8'($urandom_range(0, 3));
      r_a = 8'($urandom);
      r_b = r_a + 8'($urandom_range(0, 2));
      send_window(8'h2A, r_s, r_e);
      send_window(8'h2B, r_a, r_b);
      send_byte(1'b0, 8'h2C);
      r_n = int'($urandom_range(3, 9));
      for (int p = 0; p < r_n; p++) begin
        send_byte(1'b1, 8'($urandom));
        if ($urandom_range(0, 3) == 0) cs_release(1'b0);
        send_byte(1'b1, 8'($urandom));
      end
      check_traffic("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/lcd_spi_rx.md
Name: lcd_spi_rx

Overview:
- Receiver end of the 3-wire serial LCD link (sda, scl, cs, rs) driven by the scalescreen/lcd transmitter.
- Oversamples the link in the system clock domain and deserialises command and data bytes.
- Decodes the ST7735-style CASET (0x2A), RASET (0x2B) and RAMWR (0x2C) sequence, then emits addressed RGB565 pixels.
- Used as a loopback monitor in chip-level benches and as the front end of a future framebuffer mirror/capture path.

Parameters:
SYNC_STAGES, 2, synchroniser flops on each of sda/scl/cs/rs (minimum 2)
CMD_CASET, 8'h2A, column-window command code
CMD_RASET, 8'h2B, row-window command code
CMD_RAMWR, 8'h2C, memory-write command code

Ports:
clk  in  1  system clock (60 MHz PLL output)
reset  in  1  asynchronous active-low reset
sda  in  1  serial data, MSB first, sampled on scl rising edge
scl  in  1  serial clock, idle level irrelevant
cs  in  1  chip select, active low
rs  in  1  register select: 0 = command, 1 = data
byte_valid  out  1  one-cycle pulse: a complete byte was received
byte_data  out  8  received byte, held until next byte_valid
byte_rs  out  1  rs value sampled with bit 0 of the byte
pixel_valid  out  1  one-cycle pulse: a complete RGB565 pixel was received
pixel  out  16  pixel value, {first byte, second byte}
px  out  8  column of the pixel (low byte of window coordinate)
py  out  8  row of the pixel
frame_start  out  1  one-cycle pulse when a RAMWR command byte is accepted
frame_error  out  1  sticky flag: a byte was aborted by cs rising mid-byte; cleared by reset or frame_start

Behaviour:
- Reset (reset low, asynchronous): all outputs 0; bit counter 0; decoder in IDLE; window xs = ys = 0, xe = ye = 8'hFF; px = py = 0.
- Synchronisation: sda, scl, cs and rs each pass through SYNC_STAGES flops.
  - A scl rising edge is detected from the last two synchronised scl samples.
  - The link must hold scl high and low for at least 3 clk each; faster links are unsupported.
- Deserialiser:
  - While synchronised cs = 0, each scl rising edge shifts in sda, MSB first, and increments a 3-bit counter.
  - On the 8th edge: byte_data and byte_rs update and byte_valid pulses. Latency is 1 clk after the detected edge.
  - cs going high clears the bit counter.
  - If the counter was nonzero when cs went high, no byte is emitted and frame_error is set.
  - cs high also ends a frame: no state reset in the decoder.
- Decoder FSM, advanced only on byte_valid:
  - Any byte with byte_rs = 0 is a command and aborts any partial parameter/pixel assembly.
    - CASET -> COL (param index 0).
    - RASET -> ROW (param index 0).
    - RAMWR -> PIX, with px <= xs, py <= ys, pixel-half = 0, and frame_start pulsed on the same cycle as byte_valid+1.
    - Any other command -> IDLE.
  - COL/ROW take data bytes in order start_hi, start_lo, end_hi, end_lo.
    - Only the low bytes are stored (xs/xe or ys/ye); high bytes are ignored.
    - After the 4th byte -> IDLE.
    - Extra data bytes in IDLE are ignored.
  - PIX: the first data byte is latched as the high half.
    - The second data byte completes the pixel; pixel_valid pulses with pixel, px and py valid on the same cycle.
    - After emitting, the position advances: if px == xe then px <= xs and the row advances (if py == ye then py <= ys, else py + 1); otherwise px + 1.
    - The state remains PIX until the next command.
- Window with xs > xe: px counts upward with 8-bit wrap (8'hFF -> 0) until it equals xe. Same rule for rows.
- byte_valid and pixel_valid are never asserted by the same received byte more than once. pixel_valid lags its completing byte_valid by 1 clk.
- Reset during a byte or mid-pixel discards all partial state; no pulse is emitted.

Test Plan:
- Reset then send command 0x2A with rs = 0 -> byte_valid once, byte_data = 8'h2A, byte_rs = 0; no pixel_valid.
- CASET 00 10 00 12, RASET 00 05 00 06, RAMWR, then 12 pixel bytes 0xF8,0x00 repeated -> frame_start once, then 6 pixel_valid with pixel = 16'hF800 and (px,py) = (10,5),(11,5),(12,5),(10,6),(11,6),(12,6).
- Continue RAMWR with 2 more pixels -> positions wrap to (10,5),(11,5).
- Raise cs after 5 bits, then send a full 0x55 data byte -> no byte_valid for the partial byte, frame_error = 1, next byte_data = 8'h55.
- RAMWR, then one data byte, then command 0x00, then RAMWR and 2 data bytes -> exactly one pixel_valid, at (xs,ys); frame_error cleared by frame_start.
- Assert reset mid-byte and mid-pixel -> all outputs 0 immediately; the following clean byte decodes correctly.
